rx_ctrl: RTL and testbench



---
 rtl/rx_ctrl.sv | 89 ++++++++
 tb/tb_rx_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rx_ctrl.sv
// UART receive sequencer: qualifies the start bit at mid-bit, strobes the shift
// register once per bit period, then checks the stop bit and loads or flags an error.
module rx_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int FRAME_BITS   = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic start_bit_detected,
  input  logic serial_in,
  input  logic stop_bit,
  output logic shift_strobe,
  output logic load_buffer,
  output logic framing_error,
  output logic rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(FRAME_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] PERIOD_END = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    RECV,
    CHECK,
    LOAD,
    ERR
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] clk_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             strobe_now;

  assign strobe_now = (state == RECV) && (clk_cnt == PERIOD_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start_bit_detected) state_next = START;
      START: if (clk_cnt == HALF_LAST) state_next = serial_in ? IDLE : RECV;
      RECV:  if (strobe_now && (bit_cnt == LAST_BIT)) state_next = CHECK;
      CHECK: state_next = stop_bit ? LOAD : ERR;
      LOAD:  state_next = IDLE;
      ERR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counters restart on every state change; only START and RECV advance them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else if (state_next != state) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else if (state == START) begin
      clk_cnt <= clk_cnt + 1'b1;
    end else if (state == RECV) begin
      clk_cnt <= strobe_now ? '0 : clk_cnt + 1'b1;
      if (strobe_now) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Sticky error survives false starts; only an accepted start bit clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        framing_error <= 1'b0;
    else if (state == ERR)                          framing_error <= 1'b1;
    else if (state == START && state_next == RECV)  framing_error <= 1'b0;
  end

  always_comb begin
    shift_strobe = strobe_now;
    load_buffer  = (state == LOAD);
    rx_busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_rx_ctrl.sv
// Directed bench for rx_ctrl: cycle-by-cycle checks of strobes, load, busy and
// the sticky error flag across good, bad, glitched, reset and back-to-back frames.
module tb_rx_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_bit_detected = 1'b0;
  logic serial_in = 1'b1;
  logic stop_bit = 1'b1;
  logic shift_strobe;
  logic load_buffer;
  logic framing_error;
  logic rx_busy;

  int checks = 0;
  int failures = 0;
  logic fe_model = 1'b0;

  rx_ctrl #(.CLKS_PER_BIT(10), .FRAME_BITS(9)) dut (
    .clk                (clk),
    .rst                (rst),
    .start_bit_detected (start_bit_detected),
    .serial_in          (serial_in),
    .stop_bit           (stop_bit),
    .shift_strobe       (shift_strobe),
    .load_buffer        (load_buffer),
    .framing_error      (framing_error),
    .rx_busy            (rx_busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check_output({tag, " strobe"}, shift_strobe, 1'b0);
    check_output({tag, " load"}, load_buffer, 1'b0);
    check_output({tag, " busy"}, rx_busy, 1'b0);
    check_output({tag, " ferr"}, framing_error, fe_model);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      check_idle($sformatf("idle%0d", i));
      next_cycle();
    end
  endtask

  // Pulse start_bit_detected in an IDLE cycle; returns at START cycle 0.
  task automatic apply_stimulus();
    start_bit_detected = 1'b1;
    serial_in = 1'b0;
    check_idle("pre_start");
    next_cycle();
    start_bit_detected = 1'b0;
  endtask

  // Runs START cycles 0..96; returns at cycle 97 unless reset at rst_at.
  task automatic run_frame(input string name, input logic [7:0] data, input logic stop_val,
                           input bit extra_pulses, input int rst_at, input int exp_strobes);
    int strobes = 0;
    int idx;
    logic exp_strobe;
    logic fe_start = fe_model;
    for (int c = 0; c <= 96; c++) begin
      if (c < 4)       serial_in = 1'b1;
      else if (c == 4) serial_in = 1'b0;
      else begin
        idx = (c - 5) / 10;
        serial_in = (idx < 8) ? data[idx] : stop_val;
      end
      stop_bit = (c == 95) ? stop_val : ~stop_val;
      start_bit_detected = extra_pulses && (c == 30 || c == 60);
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        check_output($sformatf("%s rst c%0d strobe", name, c), shift_strobe, 1'b0);
        check_output($sformatf("%s rst c%0d load", name, c), load_buffer, 1'b0);
        check_output($sformatf("%s rst c%0d busy", name, c), rx_busy, 1'b0);
        check_output($sformatf("%s rst c%0d ferr", name, c), framing_error, 1'b0);
        next_cycle();
        rst = 1'b0;
        start_bit_detected = 1'b0;
        fe_model = 1'b0;
        check_output($sformatf("%s strobe count", name), (strobes == exp_strobes), 1'b1);
        idle_cycles(15);
        return;
      end
      @(negedge clk);
      exp_strobe = (c >= 14) && (c <= 94) && ((c - 14) % 10 == 0);
      if (shift_strobe === 1'b1) strobes++;
      check_output($sformatf("%s c%0d strobe", name, c), shift_strobe, exp_strobe);
      check_output($sformatf("%s c%0d load", name, c), load_buffer, stop_val && (c == 96));
      check_output($sformatf("%s c%0d busy", name, c), rx_busy, 1'b1);
      check_output($sformatf("%s c%0d ferr", name, c), framing_error, (c < 5) ? fe_start : 1'b0);
      next_cycle();
    end
    start_bit_detected = 1'b0;
    fe_model = ~stop_val;
    check_output($sformatf("%s strobe count", name), (strobes == exp_strobes), 1'b1);
  endtask

  // False start: serial_in high at the mid-bit decision cycle.
  task automatic run_glitch();
    for (int c = 0; c <= 4; c++) begin
      serial_in = (c == 4);
      stop_bit = 1'b0;
      @(negedge clk);
      check_output($sformatf("glitch c%0d busy", c), rx_busy, 1'b1);
      check_output($sformatf("glitch c%0d ferr", c), framing_error, fe_model);
      next_cycle();
    end
    serial_in = 1'b1;
    idle_cycles(20);
  endtask

  initial begin
    $display("[TB] rx_ctrl directed test start");
    #2;
    start_bit_detected = 1'b1;
    @(negedge clk);
    check_output("reset strobe", shift_strobe, 1'b0);
    check_output("reset load", load_buffer, 1'b0);
    check_output("reset busy", rx_busy, 1'b0);
    check_output("reset ferr", framing_error, 1'b0);
    start_bit_detected = 1'b0;
    next_cycle();
    rst = 1'b0;
    idle_cycles(3);

    apply_stimulus();
    run_frame("good_a5", 8'hA5, 1'b1, 1'b0, -1, 9);
    idle_cycles(2);

    apply_stimulus();
    run_frame("bad_3c", 8'h3C, 1'b0, 1'b0, -1, 9);
    idle_cycles(2);

    apply_stimulus();
    run_glitch();

    apply_stimulus();
    run_frame("extra_96", 8'h96, 1'b1, 1'b1, -1, 9);
    idle_cycles(2);

    apply_stimulus();
    run_frame("rst_11", 8'h11, 1'b0, 1'b0, 50, 4);

    apply_stimulus();
    run_frame("post_rst_ff", 8'hFF, 1'b1, 1'b0, -1, 9);
    idle_cycles(2);

    apply_stimulus();
    run_frame("b2b_bad_3c", 8'h3C, 1'b0, 1'b0, -1, 9);
    apply_stimulus();
    run_frame("b2b_good_5a", 8'h5A, 1'b1, 1'b0, -1, 9);
    idle_cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
